input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Board-input front end that sits directly upstream of the cpu/memory/display top level.
- Synchronises, debounces and edge-detects the raw push-buttons and slide switches.
- Outputs are clean levels plus single-cycle press/release/change pulses in the `clk` domain.
- The top level feeds `sw_level[3:0]` to the cpu input and uses `btn_press` for user events such as step or load.

Parameters:
- N_BTN, 3, number of push-buttons
- N_SW, 9, number of slide switches
- SYNC_STAGES, 2, synchroniser flop depth per bit (legal values 2..4)
- DEBOUNCE_CYCLES, 1_000_000, cycles a synchronised input must hold a new value before it is accepted (>=1); 20 ms at 50 MHz
- BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; outputs are always active-high
- REPEAT_DELAY, 25_000_000, autorepeat initial hold cycles (only with macro)
- REPEAT_PERIOD, 5_000_000, autorepeat interval cycles (only with macro)

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-high (1 = reset), sampled on rising `clk`
- btn_raw  input  N_BTN  asynchronous raw buttons
- sw_raw  input  N_SW  asynchronous raw switches
- btn_level  output  N_BTN  debounced button state, 1 = pressed
- btn_press  output  N_BTN  1-cycle pulse on accepted press
- btn_release  output  N_BTN  1-cycle pulse on accepted release
- sw_level  output  N_SW  debounced switch state
- sw_changed  output  N_SW  1-cycle pulse on accepted switch change (either direction)

Behaviour:
- Every bit, button or switch, has an independent path: synchroniser chain, then debounce FSM, then pulse register.
- Button bits are inverted after synchronisation when BTN_ACTIVE_LOW=1; the debouncer sees "1 = pressed".
- Reset, while `rst_n`=1 at a clock edge:
  - synchroniser flops load the raw inactive level (1 for active-low buttons, 0 otherwise);
  - all counters clear to 0, all FSMs go to STABLE;
  - btn_level, sw_level, btn_press, btn_release and sw_changed all read 0.
- Reset mid-count discards the pending change.
- After reset is released, an input physically held active is accepted through the normal debounce path. It produces a press/change pulse; no level is assumed.
- Debounce FSM per bit, `s` = synchronised value, `L` = level:
  - STABLE: counter = 0. If s != L, go to PENDING with counter = 1.
  - PENDING, s == L: bounce; go to STABLE, counter = 0, no output change.
  - PENDING, s != L, counter == DEBOUNCE_CYCLES: L <= s, assert the matching pulse for exactly the next cycle, go to STABLE.
  - PENDING otherwise: counter + 1.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). It never wraps, because it is bounded by DEBOUNCE_CYCLES.
- Latency: a clean raw edge updates the level exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles later. The pulse is high in the same cycle as the new level first appears.
- Pulses are registered outputs, never combinational from raw inputs. They are high for 1 cycle only, even if the level is held.
- Simultaneous accepted changes on several bits pulse those bits in the same cycle.
- btn_press and btn_release of one bit are mutually exclusive.
- A glitch shorter than DEBOUNCE_CYCLES+1 synchronised cycles never reaches any output.

Optional Feature:
- Macro: INPUT_CONDITIONER_AUTOREPEAT_EN.
- Defined: while btn_level[i]=1, a per-button repeat counter starts at the accepted press.
  - Additional btn_press[i] pulses fire after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - The counter clears on release or reset.
  - btn_release is unaffected. Switches never repeat.
- Undefined: exactly one btn_press per accepted press. No repeat counters or parameters are synthesised (parameters may remain declared).

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, BTN_ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset: hold rst_n=1 for 3 cycles with btn_raw=3'b111, sw_raw=0 -> all outputs 0. Release reset with inputs unchanged -> outputs stay 0 for 50 cycles.
- Clean press: btn_raw[0] 1->0 and held -> btn_level[0]=1 and btn_press[0]=1 exactly 7 cycles after the edge. The pulse lasts 1 cycle; btn_release stays 0.
- Bounce: btn_raw[1] toggles 0,1,0,1 on 1-cycle spacing, then returns to 1 -> no change on btn_level, btn_press or btn_release. The same pattern ending at 0 and held -> a single press pulse 7 cycles after the final edge.
- Switches: sw_raw 9'h000 -> 9'h105 in one cycle -> sw_level=9'h105 and sw_changed=9'h105 in the same cycle, one cycle wide. Returning to 9'h000 -> sw_changed=9'h105 again.
- Reset mid-operation: assert rst_n at counter=2 during a pending press -> level stays 0 and no pulse. After release with the button still held -> press pulse 7 cycles later.
- Autorepeat (macro defined): hold btn_raw[2]=0 for 30 cycles after acceptance -> press pulses at acceptance +0, +10, +13, +16, ... Releasing gives exactly one btn_release. Macro undefined -> only the +0 pulse.

Source files
------------

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Board-input front end: every raw push-button and slide switch bit gets its
// own synchroniser chain, debounce FSM and pulse register. Outputs are clean
// active-high levels plus single-cycle press/release/change pulses in clk.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   btn_raw      asynchronous raw buttons (active-low when BTN_ACTIVE_LOW=1)
//   sw_raw       asynchronous raw switches
//   btn_level    debounced button state, 1 = pressed
//   btn_press    1-cycle pulse on accepted press (plus repeats, see below)
//   btn_release  1-cycle pulse on accepted release
//   sw_level     debounced switch state
//   sw_changed   1-cycle pulse on accepted switch change, either direction
//
// Optional feature macro: INPUT_CONDITIONER_AUTOREPEAT_EN
//   When defined, a held button emits extra btn_press pulses REPEAT_DELAY
//   cycles after the accepted press, then every REPEAT_PERIOD cycles.
//   When undefined, no repeat logic exists and each press pulses once.
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int N_BTN           = 3,
  parameter int N_SW            = 9,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_SW-1:0]  sw_changed
);

  localparam int N_ALL = N_BTN + N_SW;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  // Configurations outside the supported range leave this block in place as
  // a visible marker in the elaborated hierarchy.
  localparam bit CFG_OK = (SYNC_STAGES >= 2) && (SYNC_STAGES <= 4) &&
                          (DEBOUNCE_CYCLES >= 1) &&
                          (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);
  if (!CFG_OK) begin : g_illegal_config
  end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
`endif

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Buttons occupy the low bits, switches the high bits.
  logic [N_ALL-1:0] w_raw;
  logic [N_ALL-1:0] w_level;
  logic [N_ALL-1:0] w_rise;
  logic [N_ALL-1:0] w_fall;
  logic [N_BTN-1:0] w_rep;

  assign w_raw = {sw_raw, btn_raw};

  for (genvar gi = 0; gi < N_ALL; gi++) begin : g_bit
    // Raw idle level; for active-low buttons it is also the inversion mask,
    // so the debouncer always sees 1 = active.
    localparam logic INACT = ((gi < N_BTN) && (BTN_ACTIVE_LOW != 0)) ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic                   w_accept;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge clk) begin
      if (rst_n) begin
        r_sync <= {SYNC_STAGES{INACT}};
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
      end
    end

    assign w_s      = r_sync[SYNC_STAGES-1] ^ INACT;
    // New value has held for the full debounce window this cycle.
    assign w_accept = (r_state == ST_PENDING) && (w_s != r_level) && (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
      if (rst_n) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        case (r_state)
          ST_STABLE: begin
            if (w_s != r_level) begin
              r_state <= ST_PENDING;
              r_cnt   <= CNT_W'(1);
            end
          end
          default: begin
            if (w_s == r_level) begin
              // Bounce back to the old value: drop the pending change.
              r_state <= ST_STABLE;
              r_cnt   <= '0;
            end else if (w_accept) begin
              r_level <= w_s;
              r_rise  <= w_s;
              r_fall  <= ~w_s;
              r_state <= ST_STABLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end

    assign w_level[gi] = r_level;
    assign w_rise[gi]  = r_rise;
    assign w_fall[gi]  = r_fall;

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    if (gi < N_BTN) begin : g_rep
      logic [REP_W-1:0] r_rep_cnt;
      logic             r_rep_periodic;
      logic             r_rep;
      logic [REP_W-1:0] w_rep_last;

      // r_rep_cnt holds cycles-since-last-pulse minus one, so the terminal
      // value is one less than the interval.
      assign w_rep_last = r_rep_periodic ? REP_W'(REPEAT_PERIOD - 1)
                                         : REP_W'(REPEAT_DELAY - 1);

      always_ff @(posedge clk) begin
        // Cleared while released and on the release-accept edge, so a
        // repeat can never coincide with btn_release.
        if (rst_n || !r_level || w_accept) begin
          r_rep_cnt      <= '0;
          r_rep_periodic <= 1'b0;
          r_rep          <= 1'b0;
        end else if (r_rep_cnt == w_rep_last) begin
          r_rep_cnt      <= '0;
          r_rep_periodic <= 1'b1;
          r_rep          <= 1'b1;
        end else begin
          r_rep_cnt <= r_rep_cnt + REP_W'(1);
          r_rep     <= 1'b0;
        end
      end

      assign w_rep[gi] = r_rep;
    end
`endif
  end

`ifndef INPUT_CONDITIONER_AUTOREPEAT_EN
  assign w_rep = '0;
`endif

  assign btn_level   = w_level[N_BTN-1:0];
  assign btn_press   = w_rise[N_BTN-1:0] | w_rep;
  assign btn_release = w_fall[N_BTN-1:0];
  assign sw_level    = w_level[N_ALL-1:N_BTN];
  assign sw_changed  = w_rise[N_ALL-1:N_BTN] | w_fall[N_ALL-1:N_BTN];

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Directed stimulus for input_conditioner with DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2, active-low buttons, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Stimulus pushes expected pulse events (cycle + full output snapshot) into a
// queue; a monitor pops one entry whenever any pulse output is high.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int LAT = 7;  // SYNC_STAGES + DEBOUNCE_CYCLES + 1

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] btn_raw;
  logic [8:0] sw_raw;
  logic [2:0] btn_level, btn_press, btn_release;
  logic [8:0] sw_level, sw_changed;

  typedef struct packed {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] blev;
    logic [8:0] chg;
    logic [8:0] slev;
  } evt_t;

  evt_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  input_conditioner #(
    .N_BTN(3), .N_SW(9), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .BTN_ACTIVE_LOW(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .sw_level(sw_level), .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle with a pulse must match the next queued event.
  always @(negedge clk) begin
    if (mon_en && ((|btn_press) || (|btn_release) || (|sw_changed))) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b rel=%b chg=%h (none expected)",
                 cyc, btn_press, btn_release, sw_changed);
      end else begin
        evt_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.press != btn_press || e.rel != btn_release ||
            e.blev != btn_level || e.chg != sw_changed || e.slev != sw_level) begin
          n_bad++;
          $display("FAIL event got cyc=%0d press=%b rel=%b blev=%b chg=%h slev=%h exp cyc=%0d press=%b rel=%b blev=%b chg=%h slev=%h",
                   cyc, btn_press, btn_release, btn_level, sw_changed, sw_level,
                   e.cyc, e.press, e.rel, e.blev, e.chg, e.slev);
        end else begin
          $display("event cyc=%0d press=%b rel=%b blev=%b chg=%h slev=%h ok",
                   cyc, btn_press, btn_release, btn_level, sw_changed, sw_level);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int dc, input logic [2:0] press, input logic [2:0] rel,
                      input logic [2:0] blev, input logic [8:0] chg, input logic [8:0] slev);
    evt_t e;
    e.cyc = cyc + dc; e.press = press; e.rel = rel;
    e.blev = blev; e.chg = chg; e.slev = slev;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", name, act, exp, cyc);
    end else begin
      $display("check %s = %h ok cyc=%0d", name, act, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b1;
    btn_raw = 3'b111;
    sw_raw  = 9'h000;
    tick(3);
    chk("rst_btn_level", {29'd0, btn_level}, 32'd0);
    chk("rst_sw_level",  {23'd0, sw_level}, 32'd0);
    chk("rst_pulses",    {17'd0, btn_press, btn_release, sw_changed}, 32'd0);

    mon_en = 1'b1;
    rst_n  = 1'b0;
    tick(50);
    chk("idle_levels", {20'd0, btn_level, sw_level}, 32'd0);

    // Clean press and release of button 0.
    btn_raw = 3'b110;
    push(LAT, 3'b001, 3'b000, 3'b001, 9'h000, 9'h000);
    tick(LAT - 1);
    chk("press_not_early", {29'd0, btn_level}, 32'd0);
    tick(14);
    chk("press_level_held", {29'd0, btn_level}, 32'd1);
    btn_raw = 3'b111;
    push(LAT, 3'b000, 3'b001, 3'b000, 9'h000, 9'h000);
    tick(20);

    // Bounce on button 1 ending released: nothing may come out.
    btn_raw = 3'b101; tick(1);
    btn_raw = 3'b111; tick(1);
    btn_raw = 3'b101; tick(1);
    btn_raw = 3'b111; tick(20);
    chk("bounce_released_level", {29'd0, btn_level}, 32'd0);

    // Same bounce ending pressed: one press LAT cycles after the final edge.
    btn_raw = 3'b101; tick(1);
    btn_raw = 3'b111; tick(1);
    btn_raw = 3'b101; tick(1);
    btn_raw = 3'b111; tick(1);
    btn_raw = 3'b101;
    push(LAT, 3'b010, 3'b000, 3'b010, 9'h000, 9'h000);
    tick(20);
    chk("bounce_pressed_level", {29'd0, btn_level}, 32'd2);
    btn_raw = 3'b111;
    push(LAT, 3'b000, 3'b010, 3'b000, 9'h000, 9'h000);
    tick(20);

    // Two buttons accepted together pulse in the same cycle.
    btn_raw = 3'b100;
    push(LAT, 3'b011, 3'b000, 3'b011, 9'h000, 9'h000);
    tick(20);
    btn_raw = 3'b111;
    push(LAT, 3'b000, 3'b011, 3'b000, 9'h000, 9'h000);
    tick(20);

    // Switches change in both directions.
    sw_raw = 9'h105;
    push(LAT, 3'b000, 3'b000, 3'b000, 9'h105, 9'h105);
    tick(20);
    chk("sw_level_set", {23'd0, sw_level}, 32'h105);
    sw_raw = 9'h000;
    push(LAT, 3'b000, 3'b000, 3'b000, 9'h105, 9'h000);
    tick(20);

    // Reset with the debounce counter at 2 discards the pending press.
    btn_raw = 3'b110;
    tick(4);
    rst_n = 1'b1;
    tick(1);
    chk("midrst_level", {29'd0, btn_level}, 32'd0);
    tick(1);
    rst_n = 1'b0;
    push(LAT, 3'b001, 3'b000, 3'b001, 9'h000, 9'h000);
    tick(20);
    btn_raw = 3'b111;
    push(LAT, 3'b000, 3'b001, 3'b000, 9'h000, 9'h000);
    tick(20);

    // Long hold of button 2; repeats only with the autorepeat build.
    btn_raw = 3'b011;
    push(LAT, 3'b100, 3'b000, 3'b100, 9'h000, 9'h000);
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    for (int t = 10; t <= 34; t += 3)
      push(LAT + t, 3'b100, 3'b000, 3'b100, 9'h000, 9'h000);
`endif
    tick(LAT + 29);
    chk("hold_level", {29'd0, btn_level}, 32'd4);
    btn_raw = 3'b111;
    push(LAT, 3'b000, 3'b100, 3'b000, 9'h000, 9'h000);
    tick(20);

    // Drain: every expected event must have been seen.
    for (int i = 0; i < 50 && q.size() != 0; i++) tick(1);
    while (q.size() != 0) begin
      evt_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_event exp cyc=%0d press=%b rel=%b chg=%h got none",
               e.cyc, e.press, e.rel, e.chg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
